prestep_coeff_engine: RTL and testbench

- Multi-cycle successor to the combinational pre-step stage.
- Builds the CGES-entry signed coefficient vector from a seed, a step value and the cges flag vector.
- Processes LANES coefficients per cycle, using a start/done handshake.
- Two modes: prefix-accumulate and masked. Output feeds the downstream coefficient consumer and is held stable until the next start.

---
 rtl/prestep_pkg.sv | 28 ++
 rtl/prestep_lane.sv | 31 +++
 rtl/prestep_coeff_engine.sv | 170 +++++++++++++++++
 tb/tb_prestep_coeff_engine.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/prestep_pkg.sv
// Shared types and helpers for the pre-step coefficient engine.
package prestep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    ACCUM = 1'b0,
    MASK  = 1'b1
  } mode_e;

  localparam int SEXT_W = 64;

  function automatic int num_groups(input int cges, input int lanes);
    return (cges + lanes - 1) / lanes;
  endfunction

  // Sign-extend the low 'bits' bits of v across the full helper width.
  function automatic logic [SEXT_W-1:0] sext_to_max(input logic [SEXT_W-1:0] v, input int bits);
    logic signed [SEXT_W-1:0] t;
    t = $signed(v << (SEXT_W - bits));
    return t >>> (SEXT_W - bits);
  endfunction

endpackage

// File: rtl/prestep_lane.sv
// Combinational LANES-wide coefficient chain: one group per RUN cycle.
module prestep_lane
  import prestep_pkg::*;
#(
  parameter int LANES = 8,
  parameter int MAX   = 38
) (
  input  logic [MAX-1:0]            sum_i,
  input  logic [MAX-1:0]            delta_i,
  input  logic [LANES-1:0]          flag_i,
  input  logic                      mode_i,
  input  logic [LANES-1:0]          lane_vld_i,
  output logic [LANES-1:0][MAX-1:0] res_o,
  output logic [MAX-1:0]            carry_o
);

  logic [LANES:0][MAX-1:0] chain;

  assign chain[0] = sum_i;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [MAX-1:0] addend;
    assign addend      = flag_i[j] ? delta_i : '0;
    // Gated lanes pass the sum through untouched.
    assign chain[j+1]  = lane_vld_i[j] ? chain[j] + addend : chain[j];
    assign res_o[j]    = (mode_i == MASK) ? addend : chain[j+1];
  end

  assign carry_o = chain[LANES];

endmodule

// File: rtl/prestep_coeff_engine.sv
// Multi-cycle pre-step coefficient engine (ACCUM / MASK), LANES coefficients per cycle.
// Optional PRESTEP_ABORT_EN adds an abort input that cancels a run in progress.
module prestep_coeff_engine
  import prestep_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int CGES  = 49,
  parameter int LANES = 8,
  parameter int MAX   = $clog2(CGES) + BITS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [BITS-1:0]  seed,
  input  logic [BITS-1:0]  delta,
  input  logic [CGES-1:1]  cges,
`ifdef PRESTEP_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             coeff_valid,
  output logic [MAX-1:0]   coeff [CGES-1:0]
);

  localparam int G    = num_groups(CGES, LANES);
  localparam int GW   = $clog2(G + 1);
  localparam int PADW = G * LANES;

  state_e                   state_q, state_d;
  logic [GW-1:0]            grp_q, grp_d;
  mode_e                    mode_q;
  logic [BITS-1:0]          seed_q, delta_q;
  logic [CGES-1:1]          cges_q;
  logic [MAX-1:0]           sum_q;
  logic [LANES-1:0][MAX-1:0] res_q;
  logic [GW-1:0]            wr_grp_q;
  logic                     wr_vld_q;
  logic                     coeff_valid_q;
  logic [MAX-1:0]           coeff_q [CGES-1:0];

  logic                     accept, compute, abort_w, wr_en;
  logic [MAX-1:0]           seed_x, delta_x, sum_in;
  logic [PADW-1:0]          flags_pad;
  logic [LANES-1:0]         flag_slice, lane_vld;
  logic [LANES-1:0][MAX-1:0] lane_res;
  logic [MAX-1:0]           lane_carry;

`ifdef PRESTEP_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    accept  = 1'b0;
    compute = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          grp_d   = '0;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (abort_w) begin
          state_d = IDLE;
          grp_d   = '0;
        end else if (grp_q == GW'(G)) begin
          // Drain cycle: the last group's registered results land this edge.
          state_d = DONE;
          grp_d   = '0;
        end else begin
          compute = 1'b1;
          grp_d   = grp_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign seed_x  = MAX'(sext_to_max(SEXT_W'(seed_q), BITS));
  assign delta_x = MAX'(sext_to_max(SEXT_W'(delta_q), BITS));
  assign sum_in  = (grp_q == '0) ? seed_x : sum_q;

  // Index 0 has no flag; it always takes the seed.
  assign flags_pad = PADW'({cges_q, 1'b0});

  always_comb begin
    flag_slice = '0;
    lane_vld   = '0;
    for (int g = 0; g < G; g++) begin
      if (grp_q == GW'(g)) begin
        flag_slice = flags_pad[g*LANES +: LANES];
        for (int j = 0; j < LANES; j++) lane_vld[j] = (g * LANES + j < CGES);
      end
    end
  end

  prestep_lane #(
    .LANES (LANES),
    .MAX   (MAX)
  ) u_lane (
    .sum_i      (sum_in),
    .delta_i    (delta_x),
    .flag_i     (flag_slice),
    .mode_i     (mode_q),
    .lane_vld_i (lane_vld),
    .res_o      (lane_res),
    .carry_o    (lane_carry)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      grp_q         <= '0;
      mode_q        <= ACCUM;
      seed_q        <= '0;
      delta_q       <= '0;
      cges_q        <= '0;
      sum_q         <= '0;
      res_q         <= '0;
      wr_grp_q      <= '0;
      wr_vld_q      <= 1'b0;
      coeff_valid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grp_q    <= grp_d;
      wr_vld_q <= compute;
      if (accept) begin
        mode_q        <= mode_e'(mode);
        seed_q        <= seed;
        delta_q       <= delta;
        cges_q        <= cges;
        sum_q         <= '0;
        coeff_valid_q <= 1'b0;
      end
      if (compute) begin
        res_q    <= lane_res;
        sum_q    <= lane_carry;
        wr_grp_q <= grp_q;
      end
      if (state_q == RUN && state_d == DONE) coeff_valid_q <= 1'b1;
    end
  end

  assign wr_en = wr_vld_q && !(state_q == RUN && abort_w);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < CGES; k++) coeff_q[k] <= '0;
    end else begin
      for (int k = 0; k < CGES; k++) begin
        if (wr_en && wr_grp_q == GW'(k / LANES))
          coeff_q[k] <= (k == 0) ? seed_x : res_q[k % LANES];
      end
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign coeff_valid = coeff_valid_q;
  assign coeff       = coeff_q;

endmodule

// File: tb/tb_prestep_coeff_engine.sv
// Directed bench for prestep_coeff_engine: LANES=8 instance plus a ragged LANES=5 instance.
module tb_prestep_coeff_engine;

  logic        clk;
  logic        reset_n;
  logic        start8, start5;
  logic        mode;
  logic [31:0] seed, delta;
  logic [48:1] cges;
`ifdef PRESTEP_ABORT_EN
  logic        abort;
`endif
  logic        busy8, done8, cv8;
  logic        busy5, done5, cv5;
  logic [37:0] c8 [48:0];
  logic [37:0] c5 [48:0];

  int checks   = 0;
  int failures = 0;

  prestep_coeff_engine #(.BITS(32), .CGES(49), .LANES(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .mode(mode),
    .seed(seed), .delta(delta), .cges(cges),
`ifdef PRESTEP_ABORT_EN
    .abort(abort),
`endif
    .busy(busy8), .done(done8), .coeff_valid(cv8), .coeff(c8)
  );

  prestep_coeff_engine #(.BITS(32), .CGES(49), .LANES(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .start(start5), .mode(mode),
    .seed(seed), .delta(delta), .cges(cges),
`ifdef PRESTEP_ABORT_EN
    .abort(1'b0),
`endif
    .busy(busy5), .done(done5), .coeff_valid(cv5), .coeff(c5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Issues one start pulse and returns the number of cycles until done (-1 on timeout).
  task automatic run_dut(input bit use5, input bit m, input logic [31:0] s,
                         input logic [31:0] d, input logic [48:1] cf, output int lat);
    int n;
    @(posedge clk); #1;
    mode = m; seed = s; delta = d; cges = cf;
    if (use5) start5 = 1'b1; else start8 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0; start8 = 1'b0;
    lat = -1; n = 0;
    while (lat < 0 && n < 40) begin
      if (use5 ? done5 : done8) lat = n;
      else begin @(posedge clk); #1; n++; end
    end
  endtask

  task automatic test_reset;
    int nz;
    reset_n = 1'b0; start8 = 0; start5 = 0; mode = 0; seed = 0; delta = 0; cges = '0;
`ifdef PRESTEP_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    nz = 0;
    for (int k = 0; k < 49; k++) if (c8[k] != '0) nz++;
    checks++; if ({busy8, done8, cv8} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b want=000", {busy8, done8, cv8}); end
    checks++; if (nz !== 0) begin failures++; $display("FAIL reset_coeff nonzero=%0d want=0", nz); end
    reset_n = 1'b1;
  endtask

  task automatic test_accum_all;
    int lat;
    logic [37:0] e;
    run_dut(1'b0, 1'b0, 32'd5, -32'sd3, '1, lat);
    checks++; if (lat !== 8) begin failures++; $display("FAIL accum_latency got=%0d want=8", lat); end
    checks++; if (cv8 !== 1'b1) begin failures++; $display("FAIL accum_valid_in_done got=%b want=1", cv8); end
    for (int k = 0; k < 49; k++) begin
      e = 38'(64'sd5 - 64'sd3 * k);
      checks++; if (c8[k] !== e) begin failures++; $display("FAIL accum_coeff[%0d] got=%0d want=%0d", k, $signed(c8[k]), $signed(e)); end
    end
    checks++; if ($signed(c8[48]) !== -38'sd139) begin failures++; $display("FAIL accum_coeff48 got=%0d want=-139", $signed(c8[48])); end
    @(posedge clk); #1;
    checks++; if ({busy8, done8, cv8} !== 3'b001) begin failures++; $display("FAIL accum_after_done got=%b want=001", {busy8, done8, cv8}); end
  endtask

  task automatic test_mask_alt;
    int lat;
    logic [48:1] cf;
    logic [37:0] e;
    for (int k = 1; k < 49; k++) cf[k] = (k % 2 == 1);
    run_dut(1'b0, 1'b1, 32'd7, 32'd4, cf, lat);
    checks++; if (lat !== 8) begin failures++; $display("FAIL mask_latency got=%0d want=8", lat); end
    for (int k = 0; k < 49; k++) begin
      e = (k == 0) ? 38'd7 : ((k % 2 == 1) ? 38'd4 : 38'd0);
      checks++; if (c8[k] !== e) begin failures++; $display("FAIL mask_coeff[%0d] got=%0d want=%0d", k, $signed(c8[k]), $signed(e)); end
    end
  endtask

  task automatic test_extreme;
    int lat;
    logic [37:0] e;
    run_dut(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, '1, lat);
    checks++; if (lat !== 8) begin failures++; $display("FAIL extreme_latency got=%0d want=8", lat); end
    for (int k = 0; k < 49; k++) begin
      e = 38'(-(64'sd1 + k) * 64'sd2147483648);
      checks++; if (c8[k] !== e) begin failures++; $display("FAIL extreme_coeff[%0d] got=%0d want=%0d", k, $signed(c8[k]), $signed(e)); end
    end
    e = 38'(-64'sd105226698752);
    checks++; if (c8[48] !== e) begin failures++; $display("FAIL extreme_coeff48 got=%0d want=%0d", $signed(c8[48]), $signed(e)); end
  endtask

  // start held high; seed and cges change every cycle.
  task automatic test_back_to_back;
    int first, second, ndone;
    logic b10, b11, v10, v11;
    logic [37:0] f0, f48, s0, s48;
    first = -1; second = -1; ndone = 0;
    b10 = 1'bx; b11 = 1'bx; v10 = 1'bx; v11 = 1'bx;
    f0 = '0; f48 = '0; s0 = '0; s48 = '0;
    @(posedge clk); #1;
    mode = 1'b0; delta = 32'd1; cges = '1; seed = 32'd10; start8 = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      seed = 32'(10 + n);
      cges = (n % 2 == 1) ? '0 : '1;
      if (done8) begin
        ndone++;
        if (first < 0) begin first = n; f0 = c8[0]; f48 = c8[48]; end
        else if (second < 0) begin second = n; s0 = c8[0]; s48 = c8[48]; end
      end
      if (n == 10) begin b10 = busy8; v10 = cv8; end
      if (n == 11) begin b11 = busy8; v11 = cv8; start8 = 1'b0; end
    end
    checks++; if (first !== 9) begin failures++; $display("FAIL b2b_first_done got=%0d want=9", first); end
    checks++; if (f0 !== 38'd10 || f48 !== 38'd58) begin failures++; $display("FAIL b2b_first_result got=%0d,%0d want=10,58", f0, f48); end
    checks++; if ({b10, v10} !== 2'b01) begin failures++; $display("FAIL b2b_idle_gap got=%b want=01", {b10, v10}); end
    checks++; if ({b11, v11} !== 2'b10) begin failures++; $display("FAIL b2b_second_accept got=%b want=10", {b11, v11}); end
    checks++; if (second !== 19) begin failures++; $display("FAIL b2b_second_done got=%0d want=19", second); end
    checks++; if (s0 !== 38'd20 || s48 !== 38'd68) begin failures++; $display("FAIL b2b_second_result got=%0d,%0d want=20,68", s0, s48); end
    checks++; if (ndone !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d want=2", ndone); end
  endtask

  task automatic test_ragged;
    int lat;
    logic [48:1] cf;
    logic [37:0] e;
    for (int k = 1; k < 49; k++) cf[k] = (k % 3 == 0);
    run_dut(1'b1, 1'b0, 32'd100, 32'd7, cf, lat);
    checks++; if (lat !== 11) begin failures++; $display("FAIL ragged_latency got=%0d want=11", lat); end
    checks++; if (cv5 !== 1'b1) begin failures++; $display("FAIL ragged_valid got=%b want=1", cv5); end
    for (int k = 0; k < 49; k++) begin
      e = 38'(100 + 7 * (k / 3));
      checks++; if (c5[k] !== e) begin failures++; $display("FAIL ragged_coeff[%0d] got=%0d want=%0d", k, $signed(c5[k]), $signed(e)); end
    end
    checks++; if (c5[48] !== 38'd212) begin failures++; $display("FAIL ragged_coeff48 got=%0d want=212", $signed(c5[48])); end
  endtask

  task automatic test_reset_midrun;
    int nz, lat;
    @(posedge clk); #1;
    mode = 1'b0; seed = 32'd3; delta = 32'd2; cges = '1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    nz = 0;
    for (int k = 0; k < 49; k++) if (c8[k] != '0) nz++;
    checks++; if ({busy8, done8, cv8} !== 3'b000) begin failures++; $display("FAIL midrun_reset_flags got=%b want=000", {busy8, done8, cv8}); end
    checks++; if (nz !== 0) begin failures++; $display("FAIL midrun_reset_coeff nonzero=%0d want=0", nz); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    run_dut(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, '1, lat);
    checks++; if (lat !== 8) begin failures++; $display("FAIL post_reset_latency got=%0d want=8", lat); end
    checks++; if (c8[0] !== 38'h3F_FFFF_FFFF) begin failures++; $display("FAIL post_reset_coeff0 got=%0d want=-1", $signed(c8[0])); end
    checks++; if (c8[48] !== 38'd95) begin failures++; $display("FAIL post_reset_coeff48 got=%0d want=95", $signed(c8[48])); end
  endtask

`ifdef PRESTEP_ABORT_EN
  task automatic test_abort;
    int nd, lat;
    @(posedge clk); #1;
    mode = 1'b0; seed = 32'd1; delta = 32'd1; cges = '1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if ({busy8, done8, cv8} !== 3'b000) begin failures++; $display("FAIL abort_idle got=%b want=000", {busy8, done8, cv8}); end
    nd = 0;
    for (int n = 0; n < 12; n++) begin
      if (done8 || cv8) nd++;
      @(posedge clk); #1;
    end
    checks++; if (nd !== 0) begin failures++; $display("FAIL abort_no_done got=%0d want=0", nd); end
    run_dut(1'b0, 1'b0, 32'd1, 32'd1, '1, lat);
    checks++; if (lat !== 8) begin failures++; $display("FAIL abort_rerun_latency got=%0d want=8", lat); end
    checks++; if (c8[48] !== 38'd49) begin failures++; $display("FAIL abort_rerun_coeff48 got=%0d want=49", $signed(c8[48])); end
  endtask
`endif

  initial begin
    test_reset();
    test_accum_all();
    test_mask_alt();
    test_extreme();
    test_back_to_back();
    test_ragged();
    test_reset_midrun();
`ifdef PRESTEP_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
